rs5_plic: RTL and testbench

Platform-level interrupt controller for the RS5 SoC. It sits on the core's data bus in the region whose address bits 31:28 fall in 0x3–0x7. It gathers `i_cnt` peripheral interrupt lines, ranks them by programmable priority against a threshold, and drives the core's machine external interrupt (`irq_o` → MEI, `irq` bit 11). Software uses a claim/complete protocol through memory-mapped registers.

---
 rtl/rs5_plic.sv | 133 +++++++++++++
 tb/tb_rs5_plic.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/rs5_plic.sv
// Platform-level interrupt controller: gateways, priority/threshold arbitration,
// claim/complete register interface and the core's machine external interrupt.
module rs5_plic #(
  parameter int i_cnt = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              en_i,
  input  logic [3:0]        we_i,
  input  logic [23:0]       addr_i,
  input  logic [31:0]       data_i,
  output logic [31:0]       data_o,
  input  logic [i_cnt:1]    irq_i,
  input  logic              iack_i,
  output logic [i_cnt:1]    iack_o,
  output logic              irq_o
);

  localparam logic [21:0] PEND_W  = 22'h000400;
  localparam logic [21:0] EN_W    = 22'h000800;
  localparam logic [21:0] THR_W   = 22'h080000;
  localparam logic [21:0] CLAIM_W = 22'h080001;

  logic [2:0]       prio [1:i_cnt];
  logic [i_cnt:1]   pending;
  logic [i_cnt:1]   enable;
  logic [i_cnt:1]   in_flight;
  logic [2:0]       threshold;
  logic             core_busy;

  logic [21:0]      word;
  logic             rd;
  logic             wr;
  logic             sel_prio;
  logic [9:0]       prio_id;
  logic             claim;
  logic             complete;
  logic [4:0]       cmp_id;
  logic [4:0]       winner;
  logic [2:0]       best;
  logic [31:0]      lane_mask;
  logic [31:0]      pend_w;
  logic [31:0]      en_w;
  logic [31:0]      en_next;
  logic [31:0]      rdata;

  assign word     = addr_i[23:2];
  assign rd       = en_i && (we_i == '0);
  assign wr       = en_i && (we_i != '0);
  assign sel_prio = (word[21:10] == '0);
  assign prio_id  = word[9:0];
  assign claim    = rd && (word == CLAIM_W);
  assign complete = wr && (word == CLAIM_W) && we_i[0];
  assign cmp_id   = data_i[4:0];

  always_comb begin
    lane_mask = '0;
    for (int unsigned b = 0; b < 4; b++) begin
      lane_mask[b*8 +: 8] = {8{we_i[b]}};
    end
    pend_w = '0;
    pend_w[i_cnt:1] = pending;
    en_w = '0;
    en_w[i_cnt:1] = enable;
    en_next = (en_w & ~lane_mask) | (data_i & lane_mask);
  end

  // Strict '>' against the running best keeps ties on the lowest id.
  always_comb begin
    winner = '0;
    best   = '0;
    for (int unsigned i = 1; i <= i_cnt; i++) begin
      if (pending[i] && enable[i] && (prio[i] > threshold) && (prio[i] > best)) begin
        winner = 5'(i);
        best   = prio[i];
      end
    end
  end

  always_comb begin
    rdata = '0;
    if (word == PEND_W) begin
      rdata = pend_w;
    end else if (word == EN_W) begin
      rdata = en_w;
    end else if (word == THR_W) begin
      rdata = {29'b0, threshold};
    end else if (word == CLAIM_W) begin
      rdata = {27'b0, winner};
    end else if (sel_prio) begin
      for (int unsigned i = 1; i <= i_cnt; i++) begin
        if (prio_id == 10'(i)) rdata = {29'b0, prio[i]};
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned i = 1; i <= i_cnt; i++) prio[i] <= '0;
      pending   <= '0;
      enable    <= '0;
      in_flight <= '0;
      threshold <= '0;
      core_busy <= 1'b0;
      data_o    <= '0;
      iack_o    <= '0;
      irq_o     <= 1'b0;
    end else begin
      data_o <= rd ? rdata : '0;
      irq_o  <= (winner != '0) && !core_busy;

      if (claim)       core_busy <= 1'b0;
      else if (iack_i) core_busy <= 1'b1;

      if (wr && (word == THR_W) && we_i[0]) threshold <= data_i[2:0];
      if (wr && (word == EN_W)) enable <= en_next[i_cnt:1];

      for (int unsigned i = 1; i <= i_cnt; i++) begin
        iack_o[i] <= claim && (winner == 5'(i));
        if (wr && sel_prio && (prio_id == 10'(i)) && we_i[0]) prio[i] <= data_i[2:0];
        // A claim overrides a same-cycle gateway set so the source stays in flight.
        if (claim && (winner == 5'(i))) begin
          pending[i]   <= 1'b0;
          in_flight[i] <= 1'b1;
        end else begin
          if (irq_i[i] && !in_flight[i]) pending[i] <= 1'b1;
          if (complete && (cmp_id == 5'(i))) in_flight[i] <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_rs5_plic.sv
// Directed bench for rs5_plic (two sources): reads are scored through an
// expected-value queue drained by a monitor; irq_o/iack_o are checked inline.
module tb_rs5_plic;

  localparam int N = 2;
  localparam logic [23:0] A_PEND  = 24'h001000;
  localparam logic [23:0] A_EN    = 24'h002000;
  localparam logic [23:0] A_THR   = 24'h200000;
  localparam logic [23:0] A_CLAIM = 24'h200004;

  logic          clk = 1'b0;
  logic          reset;
  logic          en_i;
  logic [3:0]    we_i;
  logic [23:0]   addr_i;
  logic [31:0]   data_i;
  logic [31:0]   data_o;
  logic [N:1]    irq_i;
  logic          iack_i;
  logic [N:1]    iack_o;
  logic          irq_o;

  int checks = 0;
  int errors = 0;

  logic [31:0] exp_q[$];
  string       name_q[$];
  logic        rd_q = 1'b0;

  rs5_plic #(.i_cnt(N)) dut (
    .clk(clk), .reset(reset), .en_i(en_i), .we_i(we_i), .addr_i(addr_i),
    .data_i(data_i), .data_o(data_o), .irq_i(irq_i), .iack_i(iack_i),
    .iack_o(iack_o), .irq_o(irq_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    end
  endtask

  // Monitor: a read issued at a posedge presents data_o until the next one.
  always @(posedge clk) rd_q <= !reset && en_i && (we_i == 4'h0);

  always @(negedge clk) begin
    if (rd_q) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL sb_underflow: got 0x%08h expected none", data_o);
      end else begin
        chk(name_q.pop_front(), data_o, exp_q.pop_front());
      end
    end
  end

  task automatic bus(input logic e, input logic [3:0] we, input logic [23:0] a,
                     input logic [31:0] d, input logic ack);
    @(negedge clk);
    en_i = e; we_i = we; addr_i = a; data_i = d; iack_i = ack;
  endtask

  task automatic idle(input int n = 1);
    for (int k = 0; k < n; k++) bus(1'b0, 4'h0, 24'h0, 32'h0, 1'b0);
  endtask

  task automatic wr(input logic [23:0] a, input logic [31:0] d, input logic [3:0] we = 4'hF);
    bus(1'b1, we, a, d, 1'b0);
  endtask

  task automatic rd(input logic [23:0] a, input logic [31:0] exp, input string nm,
                    input logic ack = 1'b0);
    bus(1'b1, 4'h0, a, 32'h0, ack);
    exp_q.push_back(exp);
    name_q.push_back(nm);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1; en_i = 1'b0; we_i = '0; addr_i = '0; data_i = '0;
    irq_i = '0; iack_i = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    chk("rst_irq_o", 32'(irq_o), 32'h0);
    chk("rst_iack_o", 32'(iack_o), 32'h0);
    chk("rst_data_o", data_o, 32'h0);
    rd(24'h000000, 0, "rst_prio0");
    rd(24'h000004, 0, "rst_prio1");
    rd(24'h000008, 0, "rst_prio2");
    rd(A_PEND, 0, "rst_pend");
    rd(A_EN, 0, "rst_en");
    rd(A_THR, 0, "rst_thr");
    rd(A_CLAIM, 0, "rst_claim");
    idle();
    chk("idle_data_o", data_o, 32'h0);

    // Single source: 2-cycle request latency.
    wr(24'h000004, 3);
    wr(A_EN, 32'h2);
    wr(A_THR, 0);
    idle();
    irq_i[1] = 1'b1;
    idle();
    chk("irq_lat1", 32'(irq_o), 32'h0);
    idle();
    chk("irq_lat2", 32'(irq_o), 32'h1);
    rd(A_PEND, 32'h2, "pend_src1");
    rd(24'h000004, 3, "prio1_rb");
    rd(A_EN, 32'h2, "en_rb");

    // Threshold masking.
    wr(A_THR, 3);
    idle(2);
    chk("thr3_mask", 32'(irq_o), 32'h0);
    wr(A_THR, 2);
    idle(2);
    chk("thr2_unmask", 32'(irq_o), 32'h1);

    // Core handshake, claim and complete.
    bus(1'b0, 4'h0, 24'h0, 32'h0, 1'b1);
    idle(2);
    chk("busy_mask", 32'(irq_o), 32'h0);
    rd(A_CLAIM, 1, "claim1");
    idle();
    chk("iack_pulse", 32'(iack_o), 32'h1);
    idle();
    chk("iack_once", 32'(iack_o), 32'h0);
    rd(A_PEND, 0, "pend_cleared");
    idle(3);
    chk("no_repend_irq", 32'(irq_o), 32'h0);
    rd(A_PEND, 0, "no_repend");
    wr(A_CLAIM, 1);
    idle(3);
    chk("repend_irq", 32'(irq_o), 32'h1);
    rd(A_PEND, 32'h2, "repend");

    // Two sources: tie to lowest id, then priority decides.
    wr(24'h000004, 2);
    wr(24'h000008, 2);
    wr(A_EN, 32'h6);
    wr(A_THR, 0);
    irq_i[2] = 1'b1;
    idle(2);
    wr(24'h000004, 7, 4'b1110);
    rd(24'h000004, 2, "prio_lane_masked");
    rd(A_PEND, 32'h6, "pend_both");
    rd(A_CLAIM, 1, "tie_claim1");
    idle();
    chk("tie_iack1", 32'(iack_o), 32'h1);
    rd(A_CLAIM, 2, "tie_claim2");
    idle();
    chk("tie_iack2", 32'(iack_o), 32'h2);
    wr(A_CLAIM, 1);
    wr(A_CLAIM, 2);
    idle(2);
    wr(24'h000008, 5);
    rd(A_CLAIM, 2, "prio_claim2");

    // Ignored completes, read-only pending, unmapped addresses, enable width.
    wr(A_CLAIM, 7);
    wr(A_CLAIM, 0);
    wr(A_PEND, 32'hFFFF_FFFF);
    idle(2);
    rd(A_PEND, 32'h2, "bad_complete");
    rd(24'h000100, 0, "unmapped_prio");
    rd(24'h003000, 0, "unmapped_gap");
    wr(A_EN, 32'hFFFF_FFFF);
    rd(A_EN, 32'h6, "en_width");

    // iack_i coinciding with a claim read: the clear wins.
    wr(A_CLAIM, 2);
    idle(2);
    rd(A_CLAIM, 2, "claim_with_iack", 1'b1);
    idle(2);
    chk("clear_beats_iack", 32'(irq_o), 32'h1);

    // Mid-operation reset.
    irq_i = '0;
    idle();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("mid_rst_irq_o", 32'(irq_o), 32'h0);
    chk("mid_rst_iack_o", 32'(iack_o), 32'h0);
    rd(24'h000008, 0, "mid_rst_prio2");
    rd(A_EN, 0, "mid_rst_en");
    rd(A_PEND, 0, "mid_rst_pend");
    rd(A_THR, 0, "mid_rst_thr");
    idle(3);

    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL sb_drain: got %0d expected 0 outstanding", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
